// File: rtl/bin_vote_filter.sv
// -----------------------------------------------------------------------------
// bin_vote_filter
//
// Temporal majority-vote filter for the per-frame direction bins produced by
// the localizer. It keeps the last HISTORY bin decisions in a circular buffer
// and one vote counter per bin. After each accepted decision it scans all bins
// for the strongest one. It publishes a new direction only when that bin has
// at least THRESHOLD votes and strictly beats the votes held by the currently
// published direction. Single-frame misdetections therefore never move the
// pointing/display output.
//
// Optional feature macro: BIN_VOTE_TIMEOUT_EN
//   When defined, TIMEOUT_CYCLES consecutive idle cycles without input clear
//   the vote history, confidence_out and locked_out. dir_out holds its value.
//   When undefined, history persists indefinitely.
//
// Parameters:
//   HISTORY        window depth in decisions (power of two, 2..64)
//   NUM_BINS       number of direction bins (16, matches 4-bit bin)
//   THRESHOLD      minimum votes (1..HISTORY) needed to publish a bin
//   TIMEOUT_CYCLES idle cycles before history clears (timeout build only)
//
// Ports:
//   clk_in          system clock
//   rst_in          synchronous active-high reset
//   bin_valid_in    single-cycle strobe, bin_in valid
//   bin_in          direction bin from the localizer
//   ready_out       high only while idle; input accepted only then
//   dir_valid_out   one-cycle pulse when dir_out changes
//   dir_out         current published direction
//   confidence_out  maximum vote count found by the last scan
//   locked_out      last scan's maximum count >= THRESHOLD
//   overflow_out    sticky: an input arrived while ready_out was low
// -----------------------------------------------------------------------------
module bin_vote_filter #(
  parameter int HISTORY        = 8,
  parameter int NUM_BINS       = 16,
  parameter int THRESHOLD      = 5,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       bin_valid_in,
  input  logic [3:0]                 bin_in,
  output logic                       ready_out,
  output logic                       dir_valid_out,
  output logic [3:0]                 dir_out,
  output logic [$clog2(HISTORY):0]   confidence_out,
  output logic                       locked_out,
  output logic                       overflow_out
);

  localparam int CW = $clog2(HISTORY) + 1;  // vote counter / fill width
  localparam int PW = $clog2(HISTORY);      // write pointer width
  localparam int SW = $clog2(NUM_BINS);     // scan index width

  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL  = CW'(HISTORY);
  localparam logic [CW-1:0] CNT_THR   = CW'(THRESHOLD);
  localparam logic [PW-1:0] PTR_LAST  = PW'(HISTORY - 1);
  localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0] SCAN_LAST = SW'(NUM_BINS - 1);
  localparam logic [SW-1:0] SCAN_ONE  = {{(SW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_SCAN   = 2'd2,
    S_DECIDE = 2'd3
  } state_t;

  state_t          state_q;
  logic [3:0]      hist_q [HISTORY];
  logic [CW-1:0]   cnt_q  [NUM_BINS];
  logic [PW-1:0]   ptr_q;
  logic [CW-1:0]   fill_q;
  logic [3:0]      new_bin_q;
  logic [SW-1:0]   scan_idx_q;
  logic [CW-1:0]   max_q;
  logic [3:0]      argmax_q;
  logic            ready_q;
  logic            dir_valid_q;
  logic [3:0]      dir_q;
  logic [CW-1:0]   conf_q;
  logic            locked_q;
  logic            overflow_q;

  logic            evict_d;
  logic [3:0]      old_bin_d;
  logic [CW-1:0]   scan_cnt_d;
  logic [CW-1:0]   cur_cnt_d;
  logic            change_d;
  logic            timeout_hit_d;

  // Combinational lookups shared by the UPDATE, SCAN and DECIDE steps.
  always_comb begin
    evict_d    = (fill_q == CNT_FULL);
    old_bin_d  = hist_q[ptr_q];
    scan_cnt_d = cnt_q[scan_idx_q];
    cur_cnt_d  = cnt_q[dir_q];
    // Hysteresis: a bin that only ties the current direction does not win.
    if ((max_q >= CNT_THR) && (argmax_q != dir_q) && (max_q > cur_cnt_d)) begin
      change_d = 1'b1;
    end else begin
      change_d = 1'b0;
    end
  end

`ifdef BIN_VOTE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_ONE   = {{(TW-1){1'b0}}, 1'b1};

  logic [TW-1:0] idle_cnt_q;

  // The timeout fires on the TIMEOUT_CYCLES-th consecutive idle cycle
  // without input.
  always_comb begin
    if ((state_q == S_IDLE) && !bin_valid_in && (idle_cnt_q == IDLE_LIMIT)) begin
      timeout_hit_d = 1'b1;
    end else begin
      timeout_hit_d = 1'b0;
    end
  end

  // Idle cycle counter; restarts on every accepted input and on each timeout.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idle_cnt_q <= {TW{1'b0}};
    end else if (state_q == S_IDLE) begin
      if (bin_valid_in || timeout_hit_d) begin
        idle_cnt_q <= {TW{1'b0}};
      end else begin
        idle_cnt_q <= idle_cnt_q + IDLE_ONE;
      end
    end else begin
      idle_cnt_q <= idle_cnt_q;
    end
  end
`else
  logic unused_timeout;

  // Without the timeout feature the history never ages out.
  always_comb begin
    timeout_hit_d  = 1'b0;
    unused_timeout = (TIMEOUT_CYCLES > 0);
  end
`endif

  // Main sequencer: accept, update the vote window, scan for the strongest
  // bin, then decide on the published direction.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      dir_valid_q <= 1'b0;
      dir_q       <= 4'd0;
      conf_q      <= {CW{1'b0}};
      locked_q    <= 1'b0;
      overflow_q  <= 1'b0;
      ptr_q       <= {PW{1'b0}};
      fill_q      <= {CW{1'b0}};
      new_bin_q   <= 4'd0;
      scan_idx_q  <= {SW{1'b0}};
      max_q       <= {CW{1'b0}};
      argmax_q    <= 4'd0;
      for (int i = 0; i < HISTORY; i++) begin
        hist_q[i] <= 4'd0;
      end
      for (int b = 0; b < NUM_BINS; b++) begin
        cnt_q[b] <= {CW{1'b0}};
      end
    end else begin
      dir_valid_q <= 1'b0;
      // Inputs arriving while busy are dropped and remembered.
      if (bin_valid_in && (state_q != S_IDLE)) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (bin_valid_in) begin
            new_bin_q <= bin_in;
            ready_q   <= 1'b0;
            state_q   <= S_UPDATE;
          end else if (timeout_hit_d) begin
            ptr_q    <= {PW{1'b0}};
            fill_q   <= {CW{1'b0}};
            conf_q   <= {CW{1'b0}};
            locked_q <= 1'b0;
            for (int i = 0; i < HISTORY; i++) begin
              hist_q[i] <= 4'd0;
            end
            for (int b = 0; b < NUM_BINS; b++) begin
              cnt_q[b] <= {CW{1'b0}};
            end
          end
        end
        S_UPDATE: begin
          // Evict the oldest entry once the window is full. When the evicted
          // and the new bin are the same, that counter is left untouched.
          if (evict_d && (old_bin_d != new_bin_q)) begin
            cnt_q[old_bin_d] <= cnt_q[old_bin_d] - CNT_ONE;
          end
          if (!(evict_d && (old_bin_d == new_bin_q))) begin
            cnt_q[new_bin_q] <= cnt_q[new_bin_q] + CNT_ONE;
          end
          hist_q[ptr_q] <= new_bin_q;
          if (ptr_q == PTR_LAST) begin
            ptr_q <= {PW{1'b0}};
          end else begin
            ptr_q <= ptr_q + PTR_ONE;
          end
          if (!evict_d) begin
            fill_q <= fill_q + CNT_ONE;
          end
          scan_idx_q <= {SW{1'b0}};
          max_q      <= {CW{1'b0}};
          argmax_q   <= 4'd0;
          state_q    <= S_SCAN;
        end
        S_SCAN: begin
          // Strict greater-than: ties resolve to the lowest bin index.
          if (scan_cnt_d > max_q) begin
            max_q    <= scan_cnt_d;
            argmax_q <= 4'(scan_idx_q);
          end
          if (scan_idx_q == SCAN_LAST) begin
            state_q <= S_DECIDE;
          end else begin
            scan_idx_q <= scan_idx_q + SCAN_ONE;
          end
        end
        S_DECIDE: begin
          conf_q   <= max_q;
          locked_q <= (max_q >= CNT_THR);
          if (change_d) begin
            dir_q       <= argmax_q;
            dir_valid_q <= 1'b1;
          end
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_out      = ready_q;
  assign dir_valid_out  = dir_valid_q;
  assign dir_out        = dir_q;
  assign confidence_out = conf_q;
  assign locked_out     = locked_q;
  assign overflow_out   = overflow_q;

endmodule

// File: doc/bin_vote_filter.md
# bin_vote_filter

Temporal majority-vote filter sitting directly downstream of the localizer. Consumes the per-frame 4-bit direction bin pulses, keeps a sliding window of the last HISTORY decisions with per-bin vote counters, and publishes a debounced direction only when one bin has enough votes and clearly beats the current one. Output drives the pointing/display logic, which must not jitter on single-frame misdetections.

## Interface

Parameters:
- HISTORY, 8: window depth in decisions; power of two, 2..64.
- NUM_BINS, 16: number of direction bins; matches the 4-bit bin width.
- THRESHOLD, 5: minimum vote count (1..HISTORY) for a bin to be published.
- TIMEOUT_CYCLES, 50_000_000: idle cycles before history clears; used only with the timeout feature.

Ports (one clock; reset is synchronous and active-high):
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous active-high reset.
- bin_valid_in  in  1  single-cycle pulse; bin_in is valid.
- bin_in  in  4  direction bin from the localizer.
- ready_out  out  1  high only in IDLE; inputs accepted only when high.
- dir_valid_out  out  1  one-cycle pulse when dir_out changes.
- dir_out  out  4  current published direction.
- confidence_out  out  $clog2(HISTORY)+1  max vote count from the last scan.
- locked_out  out  1  last scan's max count >= THRESHOLD.
- overflow_out  out  1  sticky; an input arrived while ready_out was low.

## Operation

- Storage: circular buffer of HISTORY 4-bit entries, write pointer (wraps HISTORY-1 -> 0), fill counter saturating at HISTORY, NUM_BINS counters of width $clog2(HISTORY)+1.
- FSM: IDLE -> UPDATE -> SCAN -> DECIDE -> IDLE.
- IDLE: on bin_valid_in, latch bin_in, go to UPDATE. Otherwise stay.
- UPDATE (1 cycle): if fill == HISTORY, decrement counter of entry at write pointer (evicted). Increment counter of new bin (same bin evicted and added: net zero). Write entry, advance pointer, bump fill.
- SCAN (NUM_BINS cycles): walk bins 0..NUM_BINS-1 tracking max count and argmax; strict greater-than compare, so ties resolve to lowest index.
- DECIDE (1 cycle): confidence_out <= max; locked_out <= (max >= THRESHOLD). Change dir_out to argmax only if max >= THRESHOLD, argmax != dir_out, and max > count[dir_out] (hysteresis: tie keeps current). On change, dir_valid_out pulses the next cycle.
- Dropped input: bin_valid_in while ready_out low -> ignored, overflow_out set until reset.
- Counters never overflow: sum of counters equals fill <= HISTORY.

## Timing

- Reset values: ready_out 1 (state IDLE), dir_valid_out 0, dir_out 0, confidence_out 0, locked_out 0, overflow_out 0; counters, fill, pointer, buffer cleared.
- Input accepted at edge E0; UPDATE occupies cycle 1, SCAN cycles 2..NUM_BINS+1, DECIDE cycle NUM_BINS+2; dir_out/confidence_out/locked_out update and dir_valid_out is high in cycle NUM_BINS+3 (19 cycles after accept at defaults), back in IDLE that same cycle.
- ready_out low for exactly NUM_BINS+2 cycles after each accept.
- Reset mid-operation: any state returns to IDLE with all storage cleared the next cycle; no dir_valid_out pulse.
- dir_out and confidence_out hold between decisions.

## Configuration

- BIN_VOTE_TIMEOUT_EN defined: a counter counts cycles in IDLE without bin_valid_in; on reaching TIMEOUT_CYCLES it clears buffer, fill, pointer, counters, confidence_out and locked_out (dir_out holds, no pulse). Any accepted input restarts the count.
- Not defined: no timeout counter; history persists indefinitely.

## Test plan

- Defaults, after reset feed bin 3 five times (spaced 40 cycles) -> no pulse for first four; after fifth, dir_out=3, dir_valid_out one cycle, confidence_out=5, locked_out=1, 19 cycles after accept.
- Continue with bin 10 x5 -> 4th gives bin3=4/bin10=4 tie: no change, locked_out=0; 5th gives bin10=5 > bin3=3: dir_out=10, pulse.
- Fresh reset, THRESHOLD=1, feed bins 7 then 2 -> dir_out=7 after first; after second, counts tie 1/1: dir_out stays 7, confidence_out=1.
- Pulse bin_valid_in 3 cycles after an accept -> ignored, overflow_out=1 sticky, confidence_out from that decision unaffected.
- Assert rst_in during SCAN -> next cycle all outputs at reset values, ready_out=1; subsequent input processes normally.
- With BIN_VOTE_TIMEOUT_EN, TIMEOUT_CYCLES=100: lock on bin 4, idle 100 cycles -> locked_out=0, confidence_out=0, dir_out=4; one more bin 4 input -> confidence_out=1.
